alu_seq: RTL and testbench

//  Parametrised, registered integer ALU with valid/ready handshakes on input and output.

---
 rtl/alu_seq.sv | 214 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit integer ALU with valid/ready handshakes on both sides.
// Ops: AND, OR, ADD, NOR, MUL, SLTU, SUB, SLT. The tag travels with the operation to the result.
// Optional feature macro: ALU_SEQ_MUL_EN enables the iterative shift-add multiplier (BUSY state).
// Without ALU_SEQ_MUL_EN, op 100 completes in one cycle with result 0, zero=1 and the other flags 0.

module alu_seq #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;
`else
    typedef enum logic [0:0] {IDLE, FULL} state_t;
`endif

    state_t state;
    state_t state_next;
    logic   accept;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic             add_ovf;
    logic             sub_ovf;
    logic             borrow;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             is_mul;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [CW-1:0]    mul_cnt;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] hi_new;
    logic [WIDTH-1:0] lo_new;
    logic             mul_last;

    // One shift-add step: add A into the upper half when the current multiplier bit is set, then shift right.
    always_comb begin
        step_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : {(WIDTH+1){1'b0}});
        hi_new   = step_sum[WIDTH:1];
        lo_new   = {step_sum[0], mul_lo[WIDTH-1:1]};
        mul_last = (mul_cnt == CW'(WIDTH-1));
        is_mul   = (in_op == OP_MUL);
    end
`endif

    // Single-cycle arithmetic/logic result and flags for the operation on the input bus.
    always_comb begin
        sum_add   = {1'b0, in_a} + {1'b0, in_b};
        sum_sub   = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_add[WIDTH-1] != in_a[WIDTH-1]);
        sub_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (sum_sub[WIDTH-1] != in_a[WIDTH-1]);
        borrow    = ~sum_sub[WIDTH];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (in_op)
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_ADD: begin
                alu_res   = sum_add[WIDTH-1:0];
                alu_carry = sum_add[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_SLTU: begin
                alu_res   = {{(WIDTH-1){1'b0}}, borrow};
                alu_carry = borrow;
            end
            OP_SUB: begin
                alu_res   = sum_sub[WIDTH-1:0];
                alu_carry = borrow;
                alu_ovf   = sub_ovf;
            end
            OP_SLT: begin
                alu_res   = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ sub_ovf};
                alu_carry = borrow;
                alu_ovf   = sub_ovf;
            end
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Handshake outputs and next state; a full slot can be refilled in the cycle it drains.
    always_comb begin
        state_next = state;
        out_valid  = (state == FULL);
        in_ready   = (state == IDLE) || ((state == FULL) && out_ready);
        accept     = in_valid && in_ready;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    state_next = is_mul ? BUSY : FULL;
`else
                    state_next = FULL;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                if (mul_last) state_next = FULL;
            end
`endif
            FULL: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    state_next = is_mul ? BUSY : FULL;
`else
                    state_next = FULL;
`endif
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result/flag registers: loaded at accept for single-cycle ops, or when the multiply finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_tag    <= '0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mul_a      <= '0;
            mul_hi     <= '0;
            mul_lo     <= '0;
            mul_cnt    <= '0;
`endif
        end else begin
            if (accept) begin
                out_tag <= in_tag;
`ifdef ALU_SEQ_MUL_EN
                if (is_mul) begin
                    mul_a   <= in_a;
                    mul_hi  <= '0;
                    mul_lo  <= in_b;
                    mul_cnt <= '0;
                end else begin
                    out_result <= alu_res;
                    out_zero   <= (alu_res == '0);
                    out_neg    <= alu_res[WIDTH-1];
                    out_carry  <= alu_carry;
                    out_ovf    <= alu_ovf;
                end
`else
                out_result <= alu_res;
                out_zero   <= (alu_res == '0);
                out_neg    <= alu_res[WIDTH-1];
                out_carry  <= alu_carry;
                out_ovf    <= alu_ovf;
`endif
            end
`ifdef ALU_SEQ_MUL_EN
            else if (state == BUSY) begin
                mul_hi  <= hi_new;
                mul_lo  <= lo_new;
                mul_cnt <= mul_cnt + CW'(1);
                if (mul_last) begin
                    out_result <= lo_new;
                    out_zero   <= (lo_new == '0);
                    out_neg    <= lo_new[WIDTH-1];
                    out_carry  <= (hi_new != '0);
                    out_ovf    <= 1'b0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32, TAG_W=5), directed vectors.
// Expected MUL behaviour follows ALU_SEQ_MUL_EN as seen by this compilation.

module tb_alu_seq;

    localparam int W  = 32;
    localparam int TW = 5;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN  = 1'b1;
    localparam int MUL_LAT = W + 1;
`else
    localparam bit MUL_EN  = 1'b0;
    localparam int MUL_LAT = 1;
`endif

    typedef struct packed {
        logic [W-1:0]  result;
        logic [TW-1:0] tag;
        logic          zero;
        logic          neg;
        logic          carry;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_zero;
    logic          out_neg;
    logic          out_carry;
    logic          out_ovf;

    exp_t sb[$];
    int   popCycles[$];
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;

    alu_seq #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Generic single-value comparison.
    task automatic checkValue(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare the presented output against the oldest scoreboard entry.
    task automatic checkOutput(input exp_t exp);
        exp_t act;
        act = '{out_result, out_tag, out_zero, out_neg, out_carry, out_ovf};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL result tag=%0d: got res=0x%08h tag=%0d z=%b n=%b c=%b v=%b expected res=0x%08h tag=%0d z=%b n=%b c=%b v=%b",
                     exp.tag, act.result, act.tag, act.zero, act.neg, act.carry, act.ovf,
                     exp.result, exp.tag, exp.zero, exp.neg, exp.carry, exp.ovf);
        end
    endtask

    // Present one operation and hold it until accepted; push its expected result at the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [TW-1:0] tag, input logic [W-1:0] res,
                                 input logic z, input logic n, input logic c, input logic v);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{res, tag, z, n, c, v});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_a     = '1;
        in_b     = '1;
        in_op    = 3'b000;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL accept tag=%0d: got no accept expected accept within 200 cycles", tag);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pop and compare whenever a result is handed over.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            popCycles.push_back(cycle);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected output: got tag=%0d res=0x%08h expected no output", out_tag, out_result);
            end else begin
                checkOutput(sb.pop_front());
            end
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish expected finish before 500000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int lat;
        bit stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        $display("[TB] start, MUL_EN=%0d", MUL_EN);

        // Reset state
        waitCycles(2);
        @(negedge clk);
        checkValue("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkValue("reset in_ready", {31'd0, in_ready}, 32'd1);
        checkValue("reset out_result", out_result, 32'd0);
        checkValue("reset flags", {28'd0, out_zero, out_neg, out_carry, out_ovf}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitCycles(1);

        // Add / subtract / compare boundary vectors
        applyStimulus(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd1, 32'h8000_0000, 0, 1, 0, 1);
        applyStimulus(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd2, 32'h0000_0000, 1, 0, 1, 0);
        applyStimulus(3'b110, 32'd5,         32'd7,         5'd3, 32'hFFFF_FFFE, 0, 1, 1, 0);
        applyStimulus(3'b111, 32'h8000_0000, 32'h0000_0001, 5'd4, 32'h0000_0001, 0, 0, 0, 1);
        applyStimulus(3'b101, 32'h8000_0000, 32'h0000_0001, 5'd5, 32'h0000_0000, 1, 0, 0, 0);
        applyStimulus(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd6, 32'h0000_0000, 1, 0, 1, 1);
        waitCycles(3);

        // Back-to-back logic ops, one result per cycle
        popCycles.delete();
        applyStimulus(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd1, 32'h00F0_00F0, 0, 0, 0, 0);
        applyStimulus(3'b001, 32'h1234_0000, 32'h0000_5678, 5'd2, 32'h1234_5678, 0, 0, 0, 0);
        applyStimulus(3'b011, 32'h0000_FFFF, 32'h00FF_0000, 5'd3, 32'hFF00_0000, 0, 1, 0, 0);
        waitCycles(3);
        checkValue("b2b result count", popCycles.size(), 32'd3);
        if (popCycles.size() == 3) begin
            checkValue("b2b spacing 1-2", popCycles[1] - popCycles[0], 32'd1);
            checkValue("b2b spacing 2-3", popCycles[2] - popCycles[1], 32'd1);
        end

        // Stall: result held with out_ready low
        out_ready = 1'b0;
        applyStimulus(3'b001, 32'h1234_0000, 32'h0000_5678, 5'd9, 32'h1234_5678, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkValue("stall out_valid", {31'd0, out_valid}, 32'd1);
            checkValue("stall in_ready", {31'd0, in_ready}, 32'd0);
            checkValue("stall out_result", out_result, 32'h1234_5678);
            checkValue("stall out_tag", {27'd0, out_tag}, 32'd9);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitCycles(2);

        // Multiply: latency and in_ready low while computing
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                if (MUL_EN) applyStimulus(3'b100, 32'h0001_0000, 32'h0001_0000, 5'd10, 32'd0, 1, 0, 1, 0);
                else        applyStimulus(3'b100, 32'h0001_0000, 32'h0001_0000, 5'd10, 32'd0, 1, 0, 0, 0);
            end else begin
                if (MUL_EN) applyStimulus(3'b100, 32'd3, 32'd7, 5'd11, 32'd21, 0, 0, 0, 0);
                else        applyStimulus(3'b100, 32'd3, 32'd7, 5'd11, 32'd0, 1, 0, 0, 0);
            end
            lat = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                lat++;
                if (out_valid) break;
                checkValue("mul busy in_ready", {31'd0, in_ready}, 32'd0);
            end
            checkValue("mul latency", lat, MUL_LAT);
            @(posedge clk);
            #1;
            waitCycles(1);
        end

        // Reset while an operation is pending
        out_ready = 1'b0;
        applyStimulus(3'b100, 32'd3, 32'd7, 5'd12, 32'd21, 0, 0, 0, 0);
        waitCycles(5);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        checkValue("mid reset in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checkValue("no stale result", {31'd0, stale}, 32'd0);
        @(posedge clk);
        #1;

        // Normal operation after reset
        applyStimulus(3'b010, 32'd100, 32'd23, 5'd13, 32'd123, 0, 0, 0, 0);
        waitCycles(3);
        checkValue("scoreboard drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
